// File: rtl/response_system_pkg.sv
// Shared types and helpers for the ticket/queue call system.
package response_system_pkg;

  localparam int NUM_COUNTERS = 5;
  localparam int TICKET_W     = 6;

  // Largest number of tickets that can be waiting at once.
  localparam logic [TICKET_W-1:0] WAIT_MAX = '1;

  // Counter identifiers as they appear on counter_call.
  typedef enum logic [2:0] {
    CALL_NONE = 3'd0,
    CALL_A    = 3'd1,
    CALL_B    = 3'd2,
    CALL_C    = 3'd3,
    CALL_D    = 3'd4,
    CALL_E    = 3'd5
  } call_e;

  // Ticket numbers run 1..63 and wrap back to 1; 0 means "no ticket".
  function automatic logic [TICKET_W-1:0] next_ticket(input logic [TICKET_W-1:0] t);
    if (t == '1) return TICKET_W'(1);
    return t + TICKET_W'(1);
  endfunction

endpackage

// File: rtl/response_system_service_counter.sv
// One service counter: goes busy when started, stays busy for
// SERVICE_CYCLES edges, and keeps the last ticket it was handed.
module service_counter
  import response_system_pkg::*;
#(
  parameter int SERVICE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [TICKET_W-1:0] ticket,
  output logic                busy,
  output logic [TICKET_W-1:0] service_number
);

  // Timer counts down from SERVICE_CYCLES-1 so busy drops exactly
  // SERVICE_CYCLES edges after the start edge.
  localparam int TW = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;

  logic [TW-1:0] timer;

  // Busy flag, service timer and held ticket.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy           <= 1'b0;
      timer          <= '0;
      service_number <= '0;
    end else if (start) begin
      busy           <= 1'b1;
      timer          <= TW'(SERVICE_CYCLES - 1);
      service_number <= ticket;
    end else if (busy) begin
      if (timer == '0) busy <= 1'b0;
      else             timer <= timer - TW'(1);
    end
  end

endmodule

// File: rtl/response_system.sv
// Ticket/queue call system with five service counters A..E.
// Optional feature macro: BUTTON_EDGE_EN (synchronised rising-edge button).
// Handshake: a press is accepted whenever fewer than 63 tickets wait; a call
// fires when at least one ticket waits and some counter is idle -- both may
// happen on the same edge.
module response_system
  import response_system_pkg::*;
#(
  parameter int SERVICE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                button,
  output logic [TICKET_W-1:0] current_number,
  output logic                counterA,
  output logic                counterB,
  output logic                counterC,
  output logic                counterD,
  output logic                counterE,
  output logic [TICKET_W-1:0] number_service,
  output logic [2:0]          counter_call,
  output logic [TICKET_W-1:0] A_serviceNumber,
  output logic [TICKET_W-1:0] B_serviceNumber,
  output logic [TICKET_W-1:0] C_serviceNumber,
  output logic [TICKET_W-1:0] D_serviceNumber,
  output logic [TICKET_W-1:0] E_serviceNumber
);

  logic                    press;
  logic                    accept;
  logic [TICKET_W-1:0]     waiting;
  logic [TICKET_W-1:0]     call_ticket;
  logic                    call_valid;
  call_e                   call_idx;
  logic [NUM_COUNTERS-1:0] busy;
  logic [NUM_COUNTERS-1:0] start;
  logic [TICKET_W-1:0]     held [NUM_COUNTERS];

`ifdef BUTTON_EDGE_EN
  logic sync1, sync2, sync_prev;

  // Two-flop synchroniser followed by a rising-edge detector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= button;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign press = sync2 & ~sync_prev;
`else
  assign press = button;
`endif

  assign accept      = press && (waiting != WAIT_MAX);
  // number_service doubles as the call pointer: the next call takes its successor.
  assign call_ticket = next_ticket(number_service);

  // Priority arbiter: lowest-lettered idle counter takes the next waiting ticket.
  always_comb begin
    start      = '0;
    call_valid = 1'b0;
    call_idx   = CALL_NONE;
    if (waiting != '0) begin
      for (int i = 0; i < NUM_COUNTERS; i++) begin
        if (!call_valid && !busy[i]) begin
          call_valid = 1'b1;
          start[i]   = 1'b1;
          call_idx   = call_e'(3'(i + 1));
        end
      end
    end
  end

  // Issue counter, waiting count, call pointer and one-cycle call strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      current_number <= '0;
      waiting        <= '0;
      number_service <= '0;
      counter_call   <= CALL_NONE;
    end else begin
      if (accept) current_number <= next_ticket(current_number);
      case ({accept, call_valid})
        2'b10:   waiting <= waiting + TICKET_W'(1);
        2'b01:   waiting <= waiting - TICKET_W'(1);
        default: waiting <= waiting;
      endcase
      if (call_valid) number_service <= call_ticket;
      counter_call <= call_idx;
    end
  end

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_counter
    service_counter #(.SERVICE_CYCLES(SERVICE_CYCLES)) u_counter (
      .clk            (clk),
      .rst            (rst),
      .start          (start[g]),
      .ticket         (call_ticket),
      .busy           (busy[g]),
      .service_number (held[g])
    );
  end

  assign counterA        = busy[0];
  assign counterB        = busy[1];
  assign counterC        = busy[2];
  assign counterD        = busy[3];
  assign counterE        = busy[4];
  assign A_serviceNumber = held[0];
  assign B_serviceNumber = held[1];
  assign C_serviceNumber = held[2];
  assign D_serviceNumber = held[3];
  assign E_serviceNumber = held[4];

endmodule

// File: tb/tb_response_system.sv
// Directed bench for response_system with a long service time so that
// counters stay busy across the wrap sequence.
module tb_response_system;

  localparam int SC = 100;

  logic       clk;
  logic       rst;
  logic       button;
  logic [5:0] current_number;
  logic       counterA, counterB, counterC, counterD, counterE;
  logic [5:0] number_service;
  logic [2:0] counter_call;
  logic [5:0] A_serviceNumber, B_serviceNumber, C_serviceNumber;
  logic [5:0] D_serviceNumber, E_serviceNumber;

  int vectors     = 0;
  int miscompares = 0;

  response_system #(.SERVICE_CYCLES(SC)) dut (
    .clk             (clk),
    .rst             (rst),
    .button          (button),
    .current_number  (current_number),
    .counterA        (counterA),
    .counterB        (counterB),
    .counterC        (counterC),
    .counterD        (counterD),
    .counterE        (counterE),
    .number_service  (number_service),
    .counter_call    (counter_call),
    .A_serviceNumber (A_serviceNumber),
    .B_serviceNumber (B_serviceNumber),
    .C_serviceNumber (C_serviceNumber),
    .D_serviceNumber (D_serviceNumber),
    .E_serviceNumber (E_serviceNumber)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive button for one edge, then sample 1 time unit after it.
  task automatic cycle(input logic b);
    button = b;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  function automatic logic [5:0] sn_of(input int i);
    case (i)
      0: return A_serviceNumber;
      1: return B_serviceNumber;
      2: return C_serviceNumber;
      3: return D_serviceNumber;
      default: return E_serviceNumber;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, " cur"},  8'(current_number), 8'd0);
    chk({tag, " busy"}, 8'({counterA, counterB, counterC, counterD, counterE}), 8'd0);
    chk({tag, " ns"},   8'(number_service), 8'd0);
    chk({tag, " cc"},   8'(counter_call), 8'd0);
    chk({tag, " snA"},  8'(A_serviceNumber), 8'd0);
    chk({tag, " snB"},  8'(B_serviceNumber), 8'd0);
    chk({tag, " snC"},  8'(C_serviceNumber), 8'd0);
    chk({tag, " snD"},  8'(D_serviceNumber), 8'd0);
    chk({tag, " snE"},  8'(E_serviceNumber), 8'd0);
  endtask

  initial begin
    button = 1'b0;
    rst    = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b0);
    chk_all_zero("idle20");

    // Six consecutive presses: A..E called in turn
    for (int k = 1; k <= 6; k++) begin
      cycle(1'b1);
      chk($sformatf("six cur%0d", k), 8'(current_number), 8'(k));
      chk($sformatf("six cc%0d", k),  8'(counter_call),   8'(k - 1));
      chk($sformatf("six ns%0d", k),  8'(number_service), 8'(k - 1));
      if (k >= 2) chk($sformatf("six sn%0d", k), 8'(sn_of(k - 2)), 8'(k - 1));
    end
    cycle(1'b0);  // edge 7: all busy, ticket 6 waits
    chk("all busy cc", 8'(counter_call), 8'd0);
    chk("all busy ns", 8'(number_service), 8'd5);
    chk("all busy flags", 8'({counterA, counterB, counterC, counterD, counterE}), 8'h1f);
    for (int i = 0; i < SC - 5; i++) cycle(1'b0);  // through edge 2+SC
    chk("A freed", 8'(counterA), 8'd0);
    chk("B still busy", 8'(counterB), 8'd1);
    chk("A freed cc", 8'(counter_call), 8'd0);
    chk("A freed snA", 8'(A_serviceNumber), 8'd1);
    cycle(1'b0);  // edge 3+SC: A re-called with ticket 6
    chk("recall cc", 8'(counter_call), 8'd1);
    chk("recall ns", 8'(number_service), 8'd6);
    chk("recall snA", 8'(A_serviceNumber), 8'd6);
    chk("recall busyA", 8'(counterA), 8'd1);
    cycle(1'b0);
    chk("recall cc drop", 8'(counter_call), 8'd0);
    chk("recall ns hold", 8'(number_service), 8'd6);
    chk("B freed", 8'(counterB), 8'd0);

    // Wrap and full queue
    do_reset();
    for (int i = 0; i < 63; i++) cycle(1'b1);
    chk("wrap cur63", 8'(current_number), 8'd63);
    chk("wrap ns", 8'(number_service), 8'd5);
    chk("wrap cc", 8'(counter_call), 8'd0);
    cycle(1'b1);
    chk("wrap cur1", 8'(current_number), 8'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1);
    chk("wrap cur5", 8'(current_number), 8'd5);  // waiting now 63
    cycle(1'b1);
    chk("full ignored", 8'(current_number), 8'd5);
    cycle(1'b1);
    chk("full ignored2", 8'(current_number), 8'd5);

    // Priority: C busy, A and B idle
    do_reset();
    cycle(1'b1);  // e1 ticket 1
    cycle(1'b1);  // e2 ticket 2, call A
    cycle(1'b1);  // e3 ticket 3, call B
    cycle(1'b0);  // e4 call C
    chk("prio C call", 8'(counter_call), 8'd3);
    for (int i = 0; i < SC - 2; i++) cycle(1'b0);  // through edge 2+SC
    cycle(1'b1);  // edge 3+SC: ticket 4 issued, B falls
    chk("prio cur4", 8'(current_number), 8'd4);
    chk("prio no call", 8'(counter_call), 8'd0);
    cycle(1'b1);  // edge 4+SC: A takes ticket 4, ticket 5 issued
    chk("prio A cc", 8'(counter_call), 8'd1);
    chk("prio A ns", 8'(number_service), 8'd4);
    chk("prio A sn", 8'(A_serviceNumber), 8'd4);
    cycle(1'b0);  // edge 5+SC: B takes ticket 5
    chk("prio B cc", 8'(counter_call), 8'd2);
    chk("prio B ns", 8'(number_service), 8'd5);
    chk("prio B sn", 8'(B_serviceNumber), 8'd5);
    chk("prio C sn held", 8'(C_serviceNumber), 8'd3);

    // Asynchronous reset while A and B are busy
    chk("pre-reset busy", 8'({counterA, counterB}), 8'b11);
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async");
    #1;
    rst = 1'b1;
    cycle(1'b1);
    chk("post reset cur", 8'(current_number), 8'd1);
    chk("post reset cc", 8'(counter_call), 8'd0);
    cycle(1'b0);
    chk("post reset call", 8'(counter_call), 8'd1);
    chk("post reset ns", 8'(number_service), 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
